reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter WIDTH, default 32: bits per register entry.
REQ-002 Parameter DEPTH, default 32: number of entries; legal 2..1024; AW = clog2(DEPTH).
REQ-003 Parameter NRD, default 2: number of independent read ports.
REQ-004 Parameter ZERO_REG, default 1: entry 0 SHALL read as 0 and ignore writes when 1.
REQ-005 Parameter BYPASS, default 1: same-cycle write-to-read forwarding enabled when 1.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 we  input  1  write request.
REQ-010 waddr  input  AW  write address.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 wr_ready  output  1  write accepted this cycle when we && wr_ready.
REQ-013 raddr  input  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-014 rdata  output  NRD*WIDTH  packed read data, port k at bits [k*WIDTH +: WIDTH].
REQ-015 clr_req  input  1  single-cycle request to zero all entries.
REQ-016 clr_busy  output  1  high while clear sequencer is walking entries.
REQ-017 clr_done  output  1  one-cycle pulse when a clear completes.

Function
REQ-018 Reads SHALL be combinational: rdata_k = entry[raddr_k], zero latency.
REQ-019 raddr_k >= DEPTH SHALL return 0; a write to waddr >= DEPTH SHALL be discarded.
REQ-020 ZERO_REG=1: raddr_k==0 SHALL return 0 regardless of bypass or stored contents.
REQ-021 Accepted write (we && wr_ready) SHALL update entry[waddr] at the next rising edge.
REQ-022 BYPASS=1: if an accepted write targets raddr_k (and is not a discarded write), rdata_k SHALL equal wdata in the same cycle; BYPASS=0: rdata_k shows old value until after the edge.
REQ-023 All NRD ports SHALL be independent; identical addresses on several ports return identical data.
REQ-024 wr_ready SHALL equal !clr_busy; a write presented while clr_busy is not accepted and the source must hold it.
REQ-025 Clear FSM states: IDLE, CLEAR, DONE; reset state IDLE.
REQ-026 IDLE: clr_req=1 -> CLEAR with pointer=0 at next edge; else stay.
REQ-027 CLEAR: each cycle zero entry[pointer], pointer++; at pointer==DEPTH-1 zero it and go to DONE.
REQ-028 DONE: clr_done=1 for exactly this cycle, then -> IDLE.
REQ-029 clr_busy SHALL be 1 in CLEAR only; clr_req in CLEAR or DONE SHALL be ignored.
REQ-030 Latency: clr_req sampled at edge N -> clr_busy high N..N+DEPTH-1, clr_done high cycle N+DEPTH.
REQ-031 Same-edge clr_req and accepted write in IDLE: write SHALL commit, then clear overwrites it.
REQ-032 Reads during CLEAR SHALL return current contents (already-cleared entries read 0); no bypass of clear zeros.

Reset
REQ-033 rst_n low SHALL immediately zero all entries, pointer, and force FSM to IDLE.
REQ-034 Reset values: clr_busy=0, clr_done=0, wr_ready=1, rdata=0 for all ports.
REQ-035 Reset asserted mid-clear SHALL abort the clear without a clr_done pulse.

Structure
REQ-036 Shared package reg_file_pkg SHALL hold the clear-FSM state enum and default parameter constants.
REQ-037 Read path SHALL instantiate NRD copies of one sub-module mux_nto1 (parametrised WIDTH, DEPTH-input selector).
REQ-038 Storage, write logic, bypass and clear FSM SHALL reside in reg_file_param.

Verification
REQ-039 Write 0xDEADBEEF to addr 5, next cycle raddr0=5 -> rdata0=0xDEADBEEF; addr 0 write 0x1234 -> raddr=0 reads 0.
REQ-040 we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 same cycle -> rdata1=0xA5A5A5A5 (BYPASS=1), old value (BYPASS=0).
REQ-041 Fill all 32 entries, pulse clr_req -> clr_busy 32 cycles, clr_done at cycle 32, all entries read 0, we ignored with wr_ready=0.
REQ-042 Drop rst_n at clear pointer 10 -> all outputs reset values immediately, no clr_done, FSM IDLE.
REQ-043 DEPTH=20, raddr0=25 -> rdata0=0; write to 25 -> no entry changes.
REQ-044 NRD=4, all ports raddr=3 after writing 0x55 -> all four rdata=0x55.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file.
// Holds the clear-sequencer state encoding and the default parameter values
// used by reg_file_param and its read-path mux.
package reg_file_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NRD      = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

endpackage

// File: rtl/mux_nto1.sv
// DEPTH-input, WIDTH-bit combinational selector.
// Ports:
//   data : packed inputs, input i at bits [i*WIDTH +: WIDTH]
//   sel  : input select
//   dout : selected input, or 0 when sel >= DEPTH
module mux_nto1
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic [DEPTH*WIDTH-1:0]   data,
  input  logic [$clog2(DEPTH)-1:0] sel,
  output logic [WIDTH-1:0]         dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(sel) == i) dout = data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised multi-read-port register file with a hardware clear sequencer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   we/waddr/wdata    : write request; accepted when we && wr_ready
//   wr_ready          : low while the clear sequencer owns the array
//   raddr/rdata       : NRD packed combinational read ports
//   clr_req           : start a clear of every entry (sampled in IDLE only)
//   clr_busy/clr_done : clear in progress / one-cycle completion pulse
//
// Clear FSM states:
//   state     | meaning
//   CLR_IDLE  | normal operation, waiting for clr_req
//   CLR_CLEAR | zeroing entry[ptr] each cycle, writes blocked
//   CLR_DONE  | clear finished, clr_done pulses for this cycle
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         wr_ready,
  input  logic [NRD*$clog2(DEPTH)-1:0] raddr,
  output logic [NRD*WIDTH-1:0]         rdata,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;

  clr_state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;

  logic waddr_ok;
  logic wr_acc;
  logic wr_commit;
  logic wr_fwd;

  assign waddr_ok  = 32'(waddr) < DEPTH_U;
  assign wr_ready  = !clr_busy;
  assign wr_acc    = we && wr_ready;
  assign wr_commit = wr_acc && waddr_ok && !(ZERO_REG != 0 && waddr == '0);
  // Forwarding is suppressed during reset so rdata reads zero while rst_n is low.
  assign wr_fwd    = rst_n && wr_acc && waddr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          ptr_d   = '0;
        end
      end
      CLR_CLEAR: begin
        clr_busy = 1'b1;
        if (32'(ptr_q) == DEPTH_U - 1) begin
          state_d = CLR_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      CLR_DONE: begin
        clr_done = 1'b1;
        state_d  = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Clear and write never collide: writes are blocked whenever CLEAR is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == CLR_CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_commit) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) mem_flat[i*WIDTH +: WIDTH] = mem[i];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] mux_out;
    logic             hit;
    logic             zero_hit;

    assign ra       = raddr[k*AW +: AW];
    assign hit      = (BYPASS != 0) && wr_fwd && (waddr == ra);
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);

    mux_nto1 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
      .data (mem_flat),
      .sel  (ra),
      .dout (mux_out)
    );

    assign rdata[k*WIDTH +: WIDTH] = zero_hit ? '0 : (hit ? wdata : mux_out);
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param.
// Instance a: defaults (32x32, 2 read ports, zero reg, bypass).
// Instance b: DEPTH=20, NRD=4, BYPASS=0.
module tb_reg_file_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_we, a_clr_req, a_wr_ready, a_clr_busy, a_clr_done;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;

  logic         b_we, b_clr_req, b_wr_ready, b_clr_busy, b_clr_done;
  logic [4:0]   b_waddr;
  logic [31:0]  b_wdata;
  logic [19:0]  b_raddr;
  logic [127:0] b_rdata;

  int n_err = 0;
  int n_chk = 0;

  reg_file_param u_a (
    .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .wr_ready(a_wr_ready), .raddr(a_raddr), .rdata(a_rdata),
    .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  reg_file_param #(.WIDTH(32), .DEPTH(20), .NRD(4), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .wr_ready(b_wr_ready), .raddr(b_raddr), .rdata(b_rdata),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
    a_we = 1'b1; a_waddr = addr; a_wdata = data;
    tick();
    a_we = 1'b0;
  endtask

  task automatic b_write(input logic [4:0] addr, input logic [31:0] data);
    b_we = 1'b1; b_waddr = addr; b_wdata = data;
    tick();
    b_we = 1'b0;
  endtask

  int busy_cnt;
  int guard;
  logic done_seen, busy_seen;

  initial begin
    rst_n = 1'b0;
    a_we = 0; a_waddr = 0; a_wdata = 0; a_raddr = 0; a_clr_req = 0;
    b_we = 0; b_waddr = 0; b_wdata = 0; b_raddr = 0; b_clr_req = 0;
    #12;
    check("rst_busy",     32'(a_clr_busy), 32'd0);
    check("rst_done",     32'(a_clr_done), 32'd0);
    check("rst_wr_ready", 32'(a_wr_ready), 32'd1);
    check("rst_rdata0",   a_rdata[31:0],   32'd0);
    check("rst_rdata1",   a_rdata[63:32],  32'd0);
    check("rst_b_rdata3", b_rdata[127:96], 32'd0);
    rst_n = 1'b1;
    tick();

    // write then read; same-cycle bypass on port 0
    a_we = 1; a_waddr = 5; a_wdata = 32'hDEADBEEF; a_raddr = {5'd0, 5'd5};
    #1;
    check("a_bypass_p0", a_rdata[31:0], 32'hDEADBEEF);
    tick();
    a_we = 0;
    #1;
    check("a_read5", a_rdata[31:0], 32'hDEADBEEF);
    a_we = 1; a_waddr = 0; a_wdata = 32'h1234; a_raddr = {5'd0, 5'd0};
    #1;
    check("a_zero_bypass", a_rdata[31:0], 32'd0);
    tick();
    a_we = 0;
    #1;
    check("a_zero_read", a_rdata[31:0], 32'd0);

    // bypass on port 1
    a_we = 1; a_waddr = 7; a_wdata = 32'hA5A5A5A5; a_raddr = {5'd7, 5'd5};
    #1;
    check("a_bypass_p1", a_rdata[63:32], 32'hA5A5A5A5);
    check("a_p0_indep",  a_rdata[31:0],  32'hDEADBEEF);
    tick();
    a_we = 0;

    // instance b: no bypass, wide fan-out, out-of-range
    b_write(5'd7, 32'h11111111);
    b_write(5'd3, 32'h55);
    b_we = 1; b_waddr = 7; b_wdata = 32'hA5A5A5A5; b_raddr = {5'd0, 5'd0, 5'd7, 5'd0};
    #1;
    check("b_nobypass_old", b_rdata[63:32], 32'h11111111);
    tick();
    b_we = 0;
    #1;
    check("b_after_edge", b_rdata[63:32], 32'hA5A5A5A5);
    b_raddr = {5'd3, 5'd3, 5'd3, 5'd3};
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("b_same_addr_p%0d", k), b_rdata[k*32 +: 32], 32'h55);
    b_raddr = {5'd3, 5'd19, 5'd9, 5'd25};
    #1;
    check("b_oor_read", b_rdata[31:0], 32'd0);
    b_write(5'd25, 32'hFFFFFFFF);
    #1;
    check("b_oor_wr_25", b_rdata[31:0],   32'd0);
    check("b_oor_wr_9",  b_rdata[63:32],  32'd0);
    check("b_oor_wr_19", b_rdata[95:64],  32'd0);
    check("b_oor_wr_3",  b_rdata[127:96], 32'h55);

    // fill and clear instance a
    for (int i = 0; i < 32; i++) a_write(5'(i), 32'h10000000 + i);
    a_raddr = {5'd0, 5'd31};
    #1;
    check("a_fill31", a_rdata[31:0],  32'h1000001F);
    check("a_fill0",  a_rdata[63:32], 32'd0);

    a_clr_req = 1;
    tick();
    a_clr_req = 0;
    a_we = 1; a_waddr = 9; a_wdata = 32'hCAFE;
    check("a_clr_wr_ready", 32'(a_wr_ready), 32'd0);
    busy_cnt = 0;
    guard = 0;
    while (a_clr_busy && guard < 64) begin
      busy_cnt++;
      a_clr_req = (busy_cnt == 4);
      if (busy_cnt == 6) begin
        a_raddr = {5'd9, 5'd10};
        #1;
        check("a_clr_mid_uncleared", a_rdata[31:0], 32'h1000000A);
      end
      if (busy_cnt == 16) begin
        #1;
        check("a_clr_mid_cleared", a_rdata[31:0],  32'd0);
        check("a_clr_held_write",  a_rdata[63:32], 32'd0);
      end
      tick();
      guard++;
    end
    a_clr_req = 0;
    check("a_clr_busy_cycles", 32'(busy_cnt),   32'd32);
    check("a_clr_done",        32'(a_clr_done), 32'd1);
    check("a_done_wr_ready",   32'(a_wr_ready), 32'd1);
    tick();
    a_we = 0;
    a_raddr = {5'd31, 5'd9};
    #1;
    check("a_done_low",   32'(a_clr_done), 32'd0);
    check("a_post_write", a_rdata[31:0],   32'hCAFE);
    check("a_post_clr31", a_rdata[63:32],  32'd0);

    // reset in the middle of a clear
    a_write(5'd20, 32'hBEEF);
    a_clr_req = 1;
    tick();
    a_clr_req = 0;
    repeat (10) tick();
    a_raddr = {5'd9, 5'd20};
    #1;
    check("a_pre_abort20", a_rdata[31:0], 32'hBEEF);
    rst_n = 0;
    #1;
    check("abort_busy",     32'(a_clr_busy), 32'd0);
    check("abort_done",     32'(a_clr_done), 32'd0);
    check("abort_wr_ready", 32'(a_wr_ready), 32'd1);
    check("abort_rdata20",  a_rdata[31:0],   32'd0);
    check("abort_b_rdata3", b_rdata[127:96], 32'd0);
    #2;
    rst_n = 1;
    done_seen = 0;
    busy_seen = 0;
    repeat (40) begin
      tick();
      done_seen |= a_clr_done;
      busy_seen |= a_clr_busy;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle",    32'(busy_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
